// File: rtl/muller_c_cover_harness.sv
// ============================================================================
// Module   : muller_c_cover_harness
// Brief    : Clocked 3-input and 2-input Muller C-elements with sticky cover
//            flags, saturating transition counters and a sticky self-check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muller_c_cover_harness #(
  parameter int   CNT_W   = 8,
  parameter logic C3_INIT = 1'b0,
  parameter logic C2_INIT = 1'b0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [5:0]       io_in,
  output logic             c3_out,
  output logic             c2_out,
  output logic [3:0]       cov_flags,
  output logic [CNT_W-1:0] c3_trans,
  output logic [CNT_W-1:0] c2_trans,
  output logic             err
);

  logic             r_c3;
  logic             r_c2;
  logic [3:0]       r_cov;
  logic [CNT_W-1:0] r_c3_trans;
  logic [CNT_W-1:0] r_c2_trans;
  logic             r_err;

  // Self-check history: previous outputs, the inputs that produced the
  // current outputs, and an enable that skips the first post-reset cycle.
  logic             r_c3_d;
  logic             r_c2_d;
  logic [5:0]       r_in_d;
  logic             r_chk_en;

  logic             w_freeze;
  logic             w_c3_nxt;
  logic             w_c2_nxt;
  logic             w_c3_rise;
  logic             w_c3_fall;
  logic             w_c2_rise;
  logic             w_c2_fall;
  logic             w_c3_bad;
  logic             w_c2_bad;

  assign w_freeze = io_in[5];

  always_comb begin
    w_c3_nxt = r_c3;
    w_c2_nxt = r_c2;
    if (!w_freeze) begin
      if (&io_in[2:0])       w_c3_nxt = 1'b1;
      else if (~|io_in[2:0]) w_c3_nxt = 1'b0;
      if (&io_in[4:3])       w_c2_nxt = 1'b1;
      else if (~|io_in[4:3]) w_c2_nxt = 1'b0;
    end
  end

  assign w_c3_rise = ~r_c3 &  w_c3_nxt;
  assign w_c3_fall =  r_c3 & ~w_c3_nxt;
  assign w_c2_rise = ~r_c2 &  w_c2_nxt;
  assign w_c2_fall =  r_c2 & ~w_c2_nxt;

  // A change is legal only if the inputs that caused it were unanimous at
  // the new value and the element was not frozen.
  always_comb begin
    w_c3_bad = 1'b0;
    w_c2_bad = 1'b0;
    if (r_c3 != r_c3_d)
      w_c3_bad = r_in_d[5] | (r_in_d[2:0] != {3{r_c3}});
    if (r_c2 != r_c2_d)
      w_c2_bad = r_in_d[5] | (r_in_d[4:3] != {2{r_c2}});
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_c3       <= C3_INIT;
      r_c2       <= C2_INIT;
      r_cov      <= 4'b0000;
      r_c3_trans <= '0;
      r_c2_trans <= '0;
      r_err      <= 1'b0;
      r_c3_d     <= C3_INIT;
      r_c2_d     <= C2_INIT;
      r_in_d     <= 6'b000000;
      r_chk_en   <= 1'b0;
    end else begin
      r_c3     <= w_c3_nxt;
      r_c2     <= w_c2_nxt;
      r_cov    <= r_cov | {w_c2_fall, w_c2_rise, w_c3_fall, w_c3_rise};
      if ((w_c3_rise | w_c3_fall) && !(&r_c3_trans))
        r_c3_trans <= r_c3_trans + 1'b1;
      if ((w_c2_rise | w_c2_fall) && !(&r_c2_trans))
        r_c2_trans <= r_c2_trans + 1'b1;
      if (r_chk_en && (w_c3_bad || w_c2_bad))
        r_err <= 1'b1;
      r_c3_d   <= r_c3;
      r_c2_d   <= r_c2;
      r_in_d   <= io_in;
      r_chk_en <= 1'b1;
    end
  end

  assign c3_out    = r_c3;
  assign c2_out    = r_c2;
  assign cov_flags = r_cov;
  assign c3_trans  = r_c3_trans;
  assign c2_trans  = r_c2_trans;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_muller_c_cover_harness.sv
// ============================================================================
// Module   : tb_muller_c_cover_harness
// Brief    : Directed self-checking bench for muller_c_cover_harness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muller_c_cover_harness;

  localparam int CNT_W = 8;

  logic             wb_clk_i;
  logic             wb_rst_i;
  logic [5:0]       io_in;
  logic             c3_out;
  logic             c2_out;
  logic [3:0]       cov_flags;
  logic [CNT_W-1:0] c3_trans;
  logic [CNT_W-1:0] c2_trans;
  logic             err;

  int n_cmp;
  int n_fail;

  muller_c_cover_harness #(
    .CNT_W   (CNT_W),
    .C3_INIT (1'b0),
    .C2_INIT (1'b0)
  ) u_dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .io_in     (io_in),
    .c3_out    (c3_out),
    .c2_out    (c2_out),
    .cov_flags (cov_flags),
    .c3_trans  (c3_trans),
    .c2_trans  (c2_trans),
    .err       (err)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply a vector for n rising edges; outputs are then sampled 1 ns later.
  task automatic step(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      io_in = v;
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input logic c3, input logic c2,
                           input logic [3:0] cov, input int t3, input int t2);
    check({tag, ".c3"},  {31'd0, c3_out}, {31'd0, c3});
    check({tag, ".c2"},  {31'd0, c2_out}, {31'd0, c2});
    check({tag, ".cov"}, {28'd0, cov_flags}, {28'd0, cov});
    check({tag, ".t3"},  {24'd0, c3_trans}, t3);
    check({tag, ".t2"},  {24'd0, c2_trans}, t2);
    check({tag, ".err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    wb_rst_i = 1'b1;
    io_in    = 6'b100101;
    step(6'b100101, 2);
    wb_rst_i = 1'b0;
    check_all("reset", 1'b0, 1'b0, 4'b0000, 0, 0);

    // Frozen with unanimous-1 inputs: nothing may change.
    step(6'b111111, 2);
    check_all("freeze_idle", 1'b0, 1'b0, 4'b0000, 0, 0);

    step(6'b000111, 1);
    check_all("c3_rise", 1'b1, 1'b0, 4'b0001, 1, 0);

    step(6'b000101, 3);
    check_all("c3_hold", 1'b1, 1'b0, 4'b0001, 1, 0);

    // C3 inputs all 0 and C2 inputs all 1: simultaneous c3 fall / c2 rise.
    step(6'b011000, 1);
    check_all("c2_rise_c3_fall", 1'b0, 1'b1, 4'b0111, 2, 1);

    step(6'b000000, 1);
    check_all("c2_fall", 1'b0, 1'b0, 4'b1111, 2, 2);

    step(6'b100111, 5);
    check_all("freeze_c3", 1'b0, 1'b0, 4'b1111, 2, 2);

    step(6'b000111, 1);
    check_all("unfreeze", 1'b1, 1'b0, 4'b1111, 3, 2);

    for (int i = 0; i < 100; i++) begin
      step(6'b011111, 1);
      step(6'b000111, 1);
    end
    check_all("sat_partial", 1'b1, 1'b0, 4'b1111, 3, 202);

    for (int i = 0; i < 200; i++) begin
      step(6'b011111, 1);
      step(6'b000111, 1);
    end
    check_all("sat_full", 1'b1, 1'b0, 4'b1111, 3, 255);

    step(6'b011111, 1);
    check_all("sat_hold", 1'b1, 1'b1, 4'b1111, 3, 255);

    step(6'b000000, 1);
    check_all("c3_fall", 1'b0, 1'b0, 4'b1111, 4, 255);

    // Reset wins over a pending c3 rise.
    wb_rst_i = 1'b1;
    step(6'b000111, 1);
    wb_rst_i = 1'b0;
    check_all("reset_mid", 1'b0, 1'b0, 4'b0000, 0, 0);

    step(6'b000111, 1);
    check_all("post_reset_rise", 1'b1, 1'b0, 4'b0001, 1, 0);

    step(6'b011111, 2);
    check_all("final", 1'b1, 1'b1, 4'b0101, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muller_c_cover_harness.md
Name: muller_c_cover_harness

Overview:
- Clocked, synthesizable model of the muller_c project's C-elements plus an on-chip property monitor, driven from the 6-bit io_in bus.
- Contains one 3-input and one 2-input Muller C-element, each evaluated once per clock.
- Provides sticky cover flags, a self-check error flag and transition counters, so formal cover runs and silicon bring-up observe the same events.

Parameters:
- CNT_W, 8, width of each saturating transition counter.
- C3_INIT, 0, value of the 3-input element output after reset.
- C2_INIT, 0, value of the 2-input element output after reset.

Ports:
- wb_clk_i  input  1  single system clock; all state updates on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- io_in  input  6  [2:0] = C3 inputs a,b,c; [4:3] = C2 inputs a,b; [5] = freeze (1 holds both elements).
- c3_out  output  1  registered 3-input C-element output.
- c2_out  output  1  registered 2-input C-element output.
- cov_flags  output  4  sticky flags: [0] c3 rose, [1] c3 fell, [2] c2 rose, [3] c2 fell.
- c3_trans  output  CNT_W  saturating count of c3_out transitions.
- c2_trans  output  CNT_W  saturating count of c2_out transitions.
- err  output  1  sticky self-check violation flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock and reset ports are wb_clk_i / wb_rst_i.
- Reset, sampled on the clock edge: c3_out=C3_INIT, c2_out=C2_INIT, cov_flags=0, c3_trans=0, c2_trans=0, err=0. Reset overrides all other activity in the same cycle, including in the middle of a transition.
- C-element update (1-cycle latency, per element, when freeze=0):
  - all inputs 1 -> output becomes 1.
  - all inputs 0 -> output becomes 0.
  - any other input mix -> output holds.
- Freeze: io_in[5]=1 holds both outputs regardless of inputs. Counters and flags still follow the held, unchanged outputs, so no events are recorded.
- Transition detection: compare each output register's next value with its current value.
  - 0->1 sets the corresponding "rose" flag and increments that element's counter.
  - 1->0 sets the "fell" flag and increments the counter.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Flags remain set until reset.
- Self-check: the monitor keeps a one-cycle-delayed copy of each output and of the inputs that were sampled.
  - err is set if an output differs from its delayed copy while the delayed inputs were not unanimous at the new value, or while the delayed freeze bit was 1.
  - err is sticky and is 0 for any correct implementation.
  - The first cycle after reset is exempt from this check.
- Both elements are independent; simultaneous transitions on c3 and c2 each update their own flags and counters in the same cycle.
- No combinational path from io_in to any output.

Test Plan:
- Reset with io_in=6'b100101, wb_rst_i=1 for 2 cycles, then low -> c3_out=0, c2_out=0, cov_flags=0, counters=0, err=0; freeze=1 keeps everything unchanged on following cycles.
- io_in=6'b000111, one edge -> c3_out=1, c3_trans=1, cov_flags=4'b0001; then io_in=6'b000101 for 3 cycles -> c3_out stays 1, c3_trans stays 1.
- io_in=6'b011000 -> c2_out=1 after one edge, cov_flags[2]=1; then io_in=6'b000000 -> c2_out=0 and c3_out=0, with c2_trans=2 and cov_flags=4'b1101 or 4'b1111 depending on prior c3 state.
- Freeze: c3_out=0, drive io_in=6'b100111 for 5 cycles -> c3_out stays 0, no counter change; clear bit 5 -> c3_out=1 on the next edge.
- Saturation: toggle the C2 inputs between 2'b11 and 2'b00 for 300 edge pairs -> c2_trans=255 and stays 255.
- Reset asserted in the same cycle as io_in=6'b000111 -> c3_out=C3_INIT, counters=0; err=0 throughout all scenarios.
